outbound_gmii_tx_framer: RTL and testbench

//  Drains the outbound FWFT frame FIFO (read side, 9-bit words: [8]=last byte of frame, [7:0]=data) and

---
 rtl/outbound_gmii_tx_framer.sv | 180 ++++++++++++++++++
 tb/tb_outbound_gmii_tx_framer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outbound_gmii_tx_framer.sv
// GMII transmit framer: drains a FWFT frame FIFO and emits preamble, SFD, data, pad, FCS and IFG.
// Underrun/oversize frames are marked with TX_ER on the wire and the remainder is discarded.
module outbound_gmii_tx_framer #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_FRAME    = 60,
   parameter int unsigned MAX_FRAME    = 1514,
   parameter int unsigned IFG_CYCLES   = 12
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [8:0] FIFO_Q,
   input  logic       FIFO_DVLD,
   output logic       FIFO_RE,
   output logic [7:0] TXD,
   output logic       TX_EN,
   output logic       TX_ER,
   output logic       FRAME_DONE,
   output logic       FRAME_ERR
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_PRE   = 4'd1;
   localparam logic [3:0] S_SFD   = 4'd2;
   localparam logic [3:0] S_DATA  = 4'd3;
   localparam logic [3:0] S_PAD   = 4'd4;
   localparam logic [3:0] S_FCS   = 4'd5;
   localparam logic [3:0] S_IFG   = 4'd6;
   localparam logic [3:0] S_ERR   = 4'd7;
   localparam logic [3:0] S_DRAIN = 4'd8;

   localparam logic [15:0] PRE_W = 16'(PREAMBLE_LEN);
   localparam logic [15:0] MIN_W = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_W = 16'(MAX_FRAME);
   localparam logic [15:0] IFG_W = 16'(IFG_CYCLES);

   logic [3:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0] crc_q, crc_d;
   logic        skip_q, skip_d;
   logic [7:0]  txd_d;
   logic        tx_en_d, tx_er_d, done_d, err_d;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign FIFO_RE = !RESET && FIFO_DVLD && ((state_q == S_DATA) || (state_q == S_DRAIN));

   // Outputs are decided one cycle ahead and registered, so each state computes what the wire shows next.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      skip_d  = skip_q;
      txd_d   = '0;
      tx_en_d = 1'b0;
      tx_er_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (FIFO_DVLD) begin
               txd_d   = 8'h55;
               tx_en_d = 1'b1;
               cnt_d   = 16'd1;
               state_d = (PRE_W > 16'd1) ? S_PRE : S_SFD;
            end
         end
         S_PRE: begin
            txd_d   = 8'h55;
            tx_en_d = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc >= PRE_W) state_d = S_SFD;
         end
         S_SFD: begin
            txd_d   = 8'hD5;
            tx_en_d = 1'b1;
            crc_d   = '1;
            cnt_d   = '0;
            state_d = S_DATA;
         end
         S_DATA: begin
            tx_en_d = 1'b1;
            if (!FIFO_DVLD || (cnt_q >= MAX_W)) begin
               // The oversize word is popped but not sent; if it closed the frame there is nothing to drain.
               tx_er_d = 1'b1;
               err_d   = 1'b1;
               skip_d  = FIFO_DVLD && FIFO_Q[8];
               state_d = S_ERR;
            end else begin
               txd_d = FIFO_Q[7:0];
               crc_d = crc32_byte(crc_q, FIFO_Q[7:0]);
               cnt_d = cnt_inc;
               if (FIFO_Q[8]) begin
                  if (cnt_inc < MIN_W) begin
                     state_d = S_PAD;
                  end else begin
                     cnt_d   = '0;
                     state_d = S_FCS;
                  end
               end
            end
         end
         S_PAD: begin
            tx_en_d = 1'b1;
            crc_d   = crc32_byte(crc_q, 8'h00);
            cnt_d   = cnt_inc;
            if (cnt_inc >= MIN_W) begin
               cnt_d   = '0;
               state_d = S_FCS;
            end
         end
         S_FCS: begin
            tx_en_d = 1'b1;
            case (cnt_q[1:0])
               2'd0:    txd_d = ~crc_q[7:0];
               2'd1:    txd_d = ~crc_q[15:8];
               2'd2:    txd_d = ~crc_q[23:16];
               default: txd_d = ~crc_q[31:24];
            endcase
            cnt_d = cnt_inc;
            if (cnt_q[1:0] == 2'd3) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IFG;
            end
         end
         S_ERR: begin
            cnt_d   = '0;
            state_d = skip_q ? S_IFG : S_DRAIN;
         end
         S_DRAIN: begin
            if (FIFO_DVLD && FIFO_Q[8]) begin
               cnt_d   = '0;
               state_d = S_IFG;
            end
         end
         S_IFG: begin
            if (cnt_q >= IFG_W) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         crc_q      <= '1;
         skip_q     <= 1'b0;
         TXD        <= '0;
         TX_EN      <= 1'b0;
         TX_ER      <= 1'b0;
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         skip_q     <= skip_d;
         TXD        <= txd_d;
         TX_EN      <= tx_en_d;
         TX_ER      <= tx_er_d;
         FRAME_DONE <= done_d;
         FRAME_ERR  <= err_d;
      end
   end

endmodule

// File: tb/tb_outbound_gmii_tx_framer.sv
// Directed bench for outbound_gmii_tx_framer: default instance plus a MIN_FRAME=0 / MAX_FRAME=16 instance,
// each fed from a FWFT FIFO model; wire bytes are captured and compared against bench-built frames.
module tb_outbound_gmii_tx_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [8:0] q_a, q_b;
   logic       dv_a, dv_b;
   logic       re_a, re_b;
   logic [7:0] txd_a, txd_b;
   logic       en_a, en_b, er_a, er_b, done_a, done_b, ferr_a, ferr_b;

   outbound_gmii_tx_framer u_a (
      .CLK(clk), .RESET(rst), .FIFO_Q(q_a), .FIFO_DVLD(dv_a), .FIFO_RE(re_a),
      .TXD(txd_a), .TX_EN(en_a), .TX_ER(er_a), .FRAME_DONE(done_a), .FRAME_ERR(ferr_a)
   );

   outbound_gmii_tx_framer #(.MIN_FRAME(0), .MAX_FRAME(16)) u_b (
      .CLK(clk), .RESET(rst), .FIFO_Q(q_b), .FIFO_DVLD(dv_b), .FIFO_RE(re_b),
      .TXD(txd_b), .TX_EN(en_b), .TX_ER(er_b), .FRAME_DONE(done_b), .FRAME_ERR(ferr_b)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [8:0]  fa[$], fb[$];
   logic [7:0]  cap_a[$], cap_b[$], exp_a[$], exp_b[$], pay[$];
   int          runs_a[$], runs_b[$], gaps_a[$];
   int          hi_a, lo_a, hi_b, rise_a, er_off_a, guard;
   int          n_done_a, n_err_a, n_done_b, n_err_b, bad_wire;
   bit          seen_a, last_re_a;
   logic [31:0] last_fcs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic step();
      logic pa, pb;
      @(negedge clk);
      dv_a = (fa.size() != 0);
      q_a  = dv_a ? fa[0] : 9'h000;
      dv_b = (fb.size() != 0);
      q_b  = dv_b ? fb[0] : 9'h000;
      #1;
      pa = re_a;
      pb = re_b;
      last_re_a = pa;
      @(posedge clk);
      if (pa) void'(fa.pop_front());
      if (pb) void'(fb.pop_front());
      #1;
      cycle++;
      if (en_a) begin
         if (hi_a == 0) begin
            if (seen_a) gaps_a.push_back(lo_a);
            rise_a = cycle;
         end
         hi_a++;
         lo_a   = 0;
         seen_a = 1'b1;
         cap_a.push_back(txd_a);
      end else begin
         if (hi_a != 0) runs_a.push_back(hi_a);
         hi_a = 0;
         lo_a++;
      end
      if (en_b) begin
         hi_b++;
         cap_b.push_back(txd_b);
      end else begin
         if (hi_b != 0) runs_b.push_back(hi_b);
         hi_b = 0;
      end
      if (er_a) er_off_a = cycle - rise_a;
      if (done_a) n_done_a++;
      if (ferr_a) n_err_a++;
      if (done_b) n_done_b++;
      if (ferr_b) n_err_b++;
      if ((!en_a && txd_a != 8'h00) || (er_a !== ferr_a) || (er_a && !en_a)) bad_wire++;
      if ((!en_b && txd_b != 8'h00) || (er_b !== ferr_b) || (er_b && !en_b)) bad_wire++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_all();
      cap_a.delete(); cap_b.delete(); exp_a.delete(); exp_b.delete();
      runs_a.delete(); runs_b.delete(); gaps_a.delete();
      hi_a = 0; lo_a = 0; hi_b = 0; seen_a = 1'b0; er_off_a = -1; rise_a = 0;
      n_done_a = 0; n_err_a = 0; n_done_b = 0; n_err_b = 0;
   endtask

   task automatic exp_push(input bit to_b, input logic [7:0] b);
      if (to_b) exp_b.push_back(b);
      else      exp_a.push_back(b);
   endtask

   task automatic push_frame(input bit to_b, input bit last);
      foreach (pay[i]) begin
         if (to_b) fb.push_back({last && (i == pay.size() - 1), pay[i]});
         else      fa.push_back({last && (i == pay.size() - 1), pay[i]});
      end
   endtask

   task automatic add_good(input bit to_b);
      logic [7:0]  fr[$];
      logic [31:0] c;
      int          minf;
      fr   = pay;
      minf = to_b ? 0 : 60;
      while (fr.size() < minf) fr.push_back(8'h00);
      c = '1;
      foreach (fr[i]) c = crc_step(c, fr[i]);
      c = ~c;
      last_fcs = c;
      for (int i = 0; i < 7; i++) exp_push(to_b, 8'h55);
      exp_push(to_b, 8'hD5);
      foreach (fr[i]) exp_push(to_b, fr[i]);
      for (int i = 0; i < 4; i++) exp_push(to_b, c[8*i +: 8]);
   endtask

   task automatic add_err(input bit to_b, input int nsent);
      for (int i = 0; i < 7; i++) exp_push(to_b, 8'h55);
      exp_push(to_b, 8'hD5);
      for (int i = 0; i < nsent; i++) exp_push(to_b, pay[i]);
      exp_push(to_b, 8'h00);
   endtask

   task automatic set_pay(input int n, input int base, input int stride);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'(base + i * stride));
   endtask

   task automatic cmp_bytes(input string tag, input bit to_b);
      int bad;
      bad = 0;
      if (to_b) begin
         check({tag, "_len"}, cap_b.size(), exp_b.size());
         for (int i = 0; i < cap_b.size() && i < exp_b.size(); i++) if (cap_b[i] !== exp_b[i]) bad++;
      end else begin
         check({tag, "_len"}, cap_a.size(), exp_a.size());
         for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++) if (cap_a[i] !== exp_a[i]) bad++;
      end
      check({tag, "_bytes"}, bad, 0);
   endtask

   function automatic int run_a(input int k);
      return (runs_a.size() > k) ? runs_a[k] : -1;
   endfunction

   function automatic int run_b(input int k);
      return (runs_b.size() > k) ? runs_b[k] : -1;
   endfunction

   function automatic logic [31:0] tail_fcs(input bit to_b);
      int n;
      n = to_b ? cap_b.size() : cap_a.size();
      if (n < 4) return 32'hDEADBEEF;
      if (to_b) return {cap_b[n-1], cap_b[n-2], cap_b[n-3], cap_b[n-4]};
      return {cap_a[n-1], cap_a[n-2], cap_a[n-3], cap_a[n-4]};
   endfunction

   initial begin
      rst = 1'b1; q_a = '0; q_b = '0; dv_a = 1'b0; dv_b = 1'b0; bad_wire = 0; last_re_a = 1'b0;
      clear_all();

      // Reset with a frame already waiting: nothing popped, all outputs low
      set_pay(60, 0, 1);
      push_frame(1'b0, 1'b1);
      run(3);
      check("rst_txd", 32'(txd_a), 32'h00);
      check("rst_txen", 32'(en_a), 32'd0);
      check("rst_txer", 32'(er_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_ferr", 32'(ferr_a), 32'd0);
      check("rst_re", 32'(last_re_a), 32'd0);
      check("rst_nopop", fa.size(), 60);
      clear_all();
      rst = 1'b0;

      // 60-byte frame, no pad
      add_good(1'b0);
      run(110);
      check("t1_run", run_a(0), 72);
      cmp_bytes("t1", 1'b0);
      check("t1_fcs", tail_fcs(1'b0), last_fcs);
      check("t1_done", n_done_a, 1);
      check("t1_err", n_err_a, 0);

      // 1-byte frame padded to 60
      clear_all();
      set_pay(1, 8'hAB, 0);
      push_frame(1'b0, 1'b1);
      add_good(1'b0);
      run(100);
      check("t2_run", run_a(0), 72);
      cmp_bytes("t2", 1'b0);
      check("t2_done", n_done_a, 1);

      // Back-to-back 64-byte frames
      clear_all();
      set_pay(64, 1, 3);
      push_frame(1'b0, 1'b1);
      add_good(1'b0);
      set_pay(64, 8'hF0, 7);
      push_frame(1'b0, 1'b1);
      add_good(1'b0);
      run(200);
      check("t5_run0", run_a(0), 76);
      check("t5_run1", run_a(1), 76);
      check("t5_gap", (gaps_a.size() > 0) ? gaps_a[0] : -1, 13);
      cmp_bytes("t5", 1'b0);
      check("t5_done", n_done_a, 2);

      // Underrun after 10 bytes, 5 trailing bytes drained, then a good 1-byte frame
      clear_all();
      set_pay(10, 8'h10, 1);
      push_frame(1'b0, 1'b0);
      add_err(1'b0, 10);
      guard = 0;
      while (fa.size() != 0 && guard < 200) begin
         step();
         guard++;
      end
      check("t4_pop_wait", 32'(guard < 200), 32'd1);
      run(5);
      set_pay(5, 8'hE0, 1);
      push_frame(1'b0, 1'b1);
      set_pay(1, 8'h77, 0);
      push_frame(1'b0, 1'b1);
      add_good(1'b0);
      run(150);
      check("t4_run_err", run_a(0), 19);
      check("t4_er_cycle", er_off_a, 18);
      check("t4_ferr", n_err_a, 1);
      check("t4_done", n_done_a, 1);
      check("t4_gap", (gaps_a.size() > 0) ? gaps_a[0] : -1, 22);
      check("t4_run_next", run_a(1), 72);
      check("t4_fifo_empty", fa.size(), 0);
      cmp_bytes("t4", 1'b0);

      // Reset on data byte 20, remainder restarts as a new frame
      clear_all();
      set_pay(40, 8'h40, 1);
      push_frame(1'b0, 1'b1);
      guard = 0;
      while (cap_a.size() < 28 && guard < 200) begin
         step();
         guard++;
      end
      check("t6_wait", 32'(guard < 200), 32'd1);
      rst = 1'b1;
      step();
      check("t6_txen", 32'(en_a), 32'd0);
      check("t6_txd", 32'(txd_a), 32'h00);
      check("t6_txer", 32'(er_a), 32'd0);
      check("t6_done", 32'(done_a), 32'd0);
      check("t6_ferr", 32'(ferr_a), 32'd0);
      check("t6_re", 32'(last_re_a), 32'd0);
      check("t6_left", fa.size(), 20);
      clear_all();
      rst = 1'b0;
      set_pay(20, 8'h54, 1);
      add_good(1'b0);
      step();
      check("t6_restart_en", 32'(en_a), 32'd1);
      check("t6_restart_txd", 32'(txd_a), 32'h55);
      run(110);
      check("t6_run", run_a(0), 72);
      cmp_bytes("t6", 1'b0);

      // MIN_FRAME=0 instance: check value "123456789"
      clear_all();
      set_pay(9, 8'h31, 1);
      push_frame(1'b1, 1'b1);
      add_good(1'b1);
      run(50);
      check("t3_run", run_b(0), 21);
      check("t3_fcs", tail_fcs(1'b1), 32'hCBF43926);
      cmp_bytes("t3", 1'b1);
      check("t3_done", n_done_b, 1);

      // MAX_FRAME=16: exact fit, oversize ending on 17th, short frame, oversize needing drain, short frame
      clear_all();
      set_pay(16, 8'hA0, 1);
      push_frame(1'b1, 1'b1);
      add_good(1'b1);
      set_pay(17, 8'hC0, 1);
      push_frame(1'b1, 1'b1);
      add_err(1'b1, 16);
      set_pay(2, 8'h11, 8'h11);
      push_frame(1'b1, 1'b1);
      add_good(1'b1);
      set_pay(20, 8'hE0, 1);
      push_frame(1'b1, 1'b1);
      add_err(1'b1, 16);
      set_pay(1, 8'h5A, 0);
      push_frame(1'b1, 1'b1);
      add_good(1'b1);
      run(300);
      check("t7_run_fit", run_b(0), 28);
      check("t7_run_ovr17", run_b(1), 25);
      check("t7_run_short", run_b(2), 14);
      check("t7_run_ovr20", run_b(3), 25);
      check("t7_run_last", run_b(4), 13);
      check("t7_done", n_done_b, 3);
      check("t7_err", n_err_b, 2);
      check("t7_fifo_empty", fb.size(), 0);
      cmp_bytes("t7", 1'b1);

      check("wire_rules", bad_wire, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
